// File: rtl/two_hot_seq_checker.sv
// Two-hot sequence checker: decodes each word, checks it against the
// expected successor and keeps sticky and saturating error status.
module two_hot_seq_checker #(
  parameter  int BW_NUM   = 4,
  parameter  int ERR_W    = 8,
  localparam int BW_SHLOC = $clog2(BW_NUM),
  localparam int NSEQ     = BW_NUM * (BW_NUM - 1) / 2,
  localparam int BW_RANK  = $clog2(NSEQ)
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                in_valid,
  input  logic [BW_NUM-1:0]   in_data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BW_SHLOC-1:0] out_left,
  output logic [BW_SHLOC-1:0] out_right,
  output logic [BW_RANK-1:0]  out_rank,
  output logic                out_fmt_err,
  output logic                out_seq_err,
  input  logic                clr_err,
  output logic                err_sticky,
  output logic [ERR_W-1:0]    err_count
);

  localparam logic [BW_SHLOC-1:0] POS_ZERO = '0;
  localparam logic [BW_SHLOC-1:0] POS_ONE  = BW_SHLOC'(1);
  localparam logic [BW_SHLOC-1:0] POS_TOP  = BW_SHLOC'(BW_NUM - 1);
  localparam logic [ERR_W-1:0]    CNT_MAX  = '1;
  localparam logic [ERR_W-1:0]    CNT_ONE  = ERR_W'(1);

  logic                accept;
  logic [31:0]         ones;
  logic                two_hot;
  logic [BW_SHLOC-1:0] hi;
  logic [BW_SHLOC-1:0] lo;
  logic [BW_RANK-1:0]  rank_c;
  logic                lo_last;
  logic                hi_top;
  logic [BW_SHLOC-1:0] nxt_l;
  logic [BW_SHLOC-1:0] nxt_r;
  logic                match;
  logic                fmt_err;
  logic                seq_err;
  logic                any_err;

  logic                valid_q, valid_d;
  logic [BW_SHLOC-1:0] left_q, left_d;
  logic [BW_SHLOC-1:0] right_q, right_d;
  logic [BW_RANK-1:0]  rank_q, rank_d;
  logic                fmt_q, fmt_d;
  logic                seq_q, seq_d;
  logic [BW_SHLOC-1:0] exp_l_q, exp_l_d;
  logic [BW_SHLOC-1:0] exp_r_q, exp_r_d;
  logic                stk_q, stk_d;
  logic [ERR_W-1:0]    cnt_q, cnt_d;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    ones = '0;
    hi   = '0;
    lo   = '0;
    for (int i = 0; i < BW_NUM; i++) begin
      if (in_data[i]) begin
        ones = ones + 32'd1;
        hi   = BW_SHLOC'(i);
      end
    end
    for (int i = BW_NUM - 1; i >= 0; i--) begin
      if (in_data[i]) lo = BW_SHLOC'(i);
    end
  end

  assign two_hot = (ones == 32'd2);
  assign rank_c  = BW_RANK'((32'(hi) * (32'(hi) - 32'd1)) / 32'd2
                   + 32'(lo));

  // Successor of the received pair, used for both advance and resync.
  assign lo_last = (lo == hi - POS_ONE);
  assign hi_top  = (hi == POS_TOP);

  always_comb begin
    nxt_l = hi;
    nxt_r = lo + POS_ONE;
    unique case (1'b1)
      lo_last && hi_top: begin
        nxt_l = POS_ONE;
        nxt_r = POS_ZERO;
      end
      lo_last && !hi_top: begin
        nxt_l = hi + POS_ONE;
        nxt_r = POS_ZERO;
      end
      default: begin
        nxt_l = hi;
        nxt_r = lo + POS_ONE;
      end
    endcase
  end

  assign match   = (hi == exp_l_q) && (lo == exp_r_q);
  assign fmt_err = !two_hot;
  assign seq_err = two_hot && !match;
  assign any_err = fmt_err || seq_err;

  always_comb begin
    valid_d = valid_q;
    left_d  = left_q;
    right_d = right_q;
    rank_d  = rank_q;
    fmt_d   = fmt_q;
    seq_d   = seq_q;
    exp_l_d = exp_l_q;
    exp_r_d = exp_r_q;
    if (accept) begin
      valid_d = 1'b1;
      fmt_d   = fmt_err;
      seq_d   = seq_err;
      if (two_hot) begin
        left_d  = hi;
        right_d = lo;
        rank_d  = rank_c;
        exp_l_d = nxt_l;
        exp_r_d = nxt_r;
      end else begin
        left_d  = '0;
        right_d = '0;
        rank_d  = '0;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // An errored accept takes priority over a simultaneous clear.
  always_comb begin
    stk_d = stk_q;
    cnt_d = cnt_q;
    if (accept && any_err) begin
      stk_d = 1'b1;
      if (clr_err)
        cnt_d = CNT_ONE;
      else if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + CNT_ONE;
    end else if (clr_err) begin
      stk_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      rank_q  <= '0;
      fmt_q   <= 1'b0;
      seq_q   <= 1'b0;
      exp_l_q <= POS_ONE;
      exp_r_q <= POS_ZERO;
      stk_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      left_q  <= left_d;
      right_q <= right_d;
      rank_q  <= rank_d;
      fmt_q   <= fmt_d;
      seq_q   <= seq_d;
      exp_l_q <= exp_l_d;
      exp_r_q <= exp_r_d;
      stk_q   <= stk_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_left    = left_q;
  assign out_right   = right_q;
  assign out_rank    = rank_q;
  assign out_fmt_err = fmt_q;
  assign out_seq_err = seq_q;
  assign err_sticky  = stk_q;
  assign err_count   = cnt_q;

endmodule

// File: tb/tb_two_hot_seq_checker.sv
// Bench for two_hot_seq_checker: table-driven reference model feeding
// a result queue that is compared when the checker presents output.
module tb_two_hot_seq_checker;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] out_left;
  logic [1:0] out_right;
  logic [2:0] out_rank;
  logic       out_fmt_err;
  logic       out_seq_err;
  logic       clr_err = 1'b0;
  logic       err_sticky;
  logic [1:0] err_count;

  two_hot_seq_checker #(.BW_NUM(4), .ERR_W(2)) dut (
    .clk(clk), .rst_b(rst_b),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_left(out_left), .out_right(out_right), .out_rank(out_rank),
    .out_fmt_err(out_fmt_err), .out_seq_err(out_seq_err),
    .clr_err(clr_err), .err_sticky(err_sticky), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] l;
    logic [1:0] r;
    logic [2:0] rk;
    logic       fe;
    logic       se;
  } res_t;

  res_t q[$];
  logic [3:0] SEQ [6] = '{4'd3, 4'd5, 4'd6, 4'd9, 4'd10, 4'd12};
  int LT [6] = '{1, 2, 2, 3, 3, 3};
  int RT [6] = '{0, 0, 1, 0, 1, 2};

  int nchk = 0;
  int nfail = 0;
  int nres = 0;
  int stalls = 0;
  int m_exp = 0;
  int m_cnt = 0;
  int m_stk = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] w, input logic c);
    res_t r;
    int k;
    r = '{l: 2'd0, r: 2'd0, rk: 3'd0, fe: 1'b0, se: 1'b0};
    if ($countones(w) != 2) begin
      r.fe = 1'b1;
    end else begin
      k = 0;
      for (int i = 0; i < 6; i++) if (SEQ[i] == w) k = i;
      r.l  = 2'(LT[k]);
      r.r  = 2'(RT[k]);
      r.rk = 3'(k);
      r.se = (k != m_exp);
      m_exp = (k + 1) % 6;
    end
    if (r.fe || r.se) begin
      m_stk = 1;
      m_cnt = c ? 1 : ((m_cnt == 3) ? 3 : m_cnt + 1);
    end else if (c) begin
      m_stk = 0;
      m_cnt = 0;
    end
    q.push_back(r);
  endtask

  task automatic send(input logic [3:0] w, input logic c = 1'b0);
    int n;
    logic acc;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    clr_err  = c;
    n = 0;
    forever begin
      #1 acc = in_ready;
      @(posedge clk);
      if (acc) break;
      stalls++;
      n++;
      if (n > 20) begin
        chk("send_timeout", 32'(acc), 1);
        break;
      end
      @(negedge clk);
    end
    if (acc) model(w, c);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    clr_err  = 1'b0;
    @(negedge clk);
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    clr_err   = 1'b0;
    out_ready = 1'b1;
    rst_b     = 1'b0;
    q.delete();
    m_exp = 0;
    m_cnt = 0;
    m_stk = 0;
    @(negedge clk);
    #1 rst_b = 1'b1;
    #2;
  endtask

  task automatic chk_err(input string tag);
    chk({tag, "_cnt"}, 32'(err_count), 32'(m_cnt));
    chk({tag, "_stk"}, 32'(err_sticky), 32'(m_stk));
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_b) begin
      if (out_valid) begin
        chk("lat_q", 32'(q.size()), 1);
        if (q.size() > 0) begin
          chk("left", 32'(out_left), 32'(q[0].l));
          chk("right", 32'(out_right), 32'(q[0].r));
          chk("rank", 32'(out_rank), 32'(q[0].rk));
          chk("fmt", 32'(out_fmt_err), 32'(q[0].fe));
          chk("seq", 32'(out_seq_err), 32'(q[0].se));
          if (out_ready) begin
            void'(q.pop_front());
            nres++;
          end
        end
      end else begin
        chk("idle_q", 32'(q.size()), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;

    do_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_left", 32'(out_left), 0);
    chk("rst_right", 32'(out_right), 0);
    chk("rst_rank", 32'(out_rank), 0);
    chk("rst_fmt", 32'(out_fmt_err), 0);
    chk("rst_seq", 32'(out_seq_err), 0);
    chk_err("rst");

    stalls = 0;
    r0 = nres;
    send(4'd3); send(4'd5); send(4'd6); send(4'd9);
    send(4'd10); send(4'd12); send(4'd3);
    idle();
    chk("seq_stalls", 32'(stalls), 0);
    chk("seq_nres", 32'(nres - r0), 7);
    chk_err("seq");

    do_reset();
    send(4'd3); send(4'd5); send(4'd9); send(4'd10);
    idle();
    chk_err("skip");
    chk("skip_cnt_abs", 32'(err_count), 1);

    do_reset();
    send(4'd3); send(4'd7); send(4'd0); send(4'd5);
    idle();
    chk_err("fmt");
    chk("fmt_cnt_abs", 32'(err_count), 2);

    do_reset();
    stalls = 0;
    r0 = nres;
    send(4'd3);
    fork
      send(4'd5);
      begin
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) begin
          #2;
          chk("bp_ready", 32'(in_ready), 0);
          chk("bp_valid", 32'(out_valid), 1);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    send(4'd6);
    idle();
    chk("bp_stalls", 32'(stalls), 3);
    chk("bp_nres", 32'(nres - r0), 3);
    chk_err("bp");

    do_reset();
    repeat (5) send(4'd0);
    idle();
    chk_err("sat");
    chk("sat_cnt_abs", 32'(err_count), 3);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_cnt = 0;
    m_stk = 0;
    #3;
    chk_err("clr");
    send(4'd7, 1'b1);
    idle();
    chk_err("clr_err_win");
    chk("clr_win_abs", 32'(err_count), 1);

    do_reset();
    send(4'd3);
    send(4'd5);
    #2;
    chk("ar_valid_pre", 32'(out_valid), 1);
    in_valid = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("ar_valid_drop", 32'(out_valid), 0);
    q.delete();
    m_exp = 0;
    m_cnt = 0;
    m_stk = 0;
    @(negedge clk);
    #1 rst_b = 1'b1;
    send(4'd3);
    send(4'd6);
    idle();
    chk_err("ar");
    chk("ar_cnt_abs", 32'(err_count), 1);

    chk("end_q", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/two_hot_seq_checker.md
Name: two_hot_seq_checker

Overview:
- Receive-side counterpart of the two-hot sequence generator.
- Accepts a stream of BW_NUM-bit words, checks that each word has exactly two bits set, and decodes the left (high) and right (low) bit positions plus the word's rank in the canonical sequence.
- Verifies that each word is the expected successor of the previous one, resynchronises after a mismatch, and keeps sticky and counted error status.
- Sits at the consumer end of a generator link, behind a valid/ready handshake with a one-stage registered output.

Parameters:
- BW_NUM, 4, word width; legal range BW_NUM >= 3.
- ERR_W, 8, width of the saturating error counter.
- Derived, not overridable: BW_SHLOC = $clog2(BW_NUM); NSEQ = BW_NUM*(BW_NUM-1)/2; BW_RANK = $clog2(NSEQ).

Ports:
- clk  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_data  in  BW_NUM  input word.
- in_ready  out  1  checker can accept a word.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  downstream accepts result.
- out_left  out  BW_SHLOC  index of highest set bit.
- out_right  out  BW_SHLOC  index of lowest set bit.
- out_rank  out  BW_RANK  position of the word in the sequence.
- out_fmt_err  out  1  word does not have exactly two bits set.
- out_seq_err  out  1  word is two-hot but is not the expected successor.
- clr_err  in  1  clear sticky flag and error counter.
- err_sticky  out  1  set by any error since reset or clear.
- err_count  out  ERR_W  saturating count of errored words.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_b is asynchronous and active-low.
- Canonical sequence: pairs (left,right) with left>right, ordered by left ascending, then right ascending. It starts at (1,0) and wraps after (BW_NUM-1,BW_NUM-2) back to (1,0).
  - For BW_NUM=4 the word order is 3,5,6,9,10,12,3,...
- Successor rule: if right==left-1, the next pair is (left+1,0), or (1,0) when left==BW_NUM-1. Otherwise the next pair is (left,right+1).
- Rank: rank = left*(left-1)/2 + right, computed at full width and truncated to BW_RANK.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational.
  - A word is accepted when in_valid && in_ready.
  - Accepted result appears registered on out_* the next cycle; latency 1.
  - out_* holds stable while out_valid && !out_ready.
  - Back-to-back full throughput when out_ready=1.
- Decode: popcount(in_data) != 2 gives out_fmt_err=1, out_seq_err=0, out_left=out_right=out_rank=0.
- Expected-pair state register: (exp_left,exp_right), reset to (1,0). On each accepted word:
  - Two-hot and equal to expected: no error; expected advances to the successor of the received pair.
  - Two-hot and not equal to expected: out_seq_err=1; expected resyncs to the successor of the received pair.
  - Format error: expected unchanged.
- Errors: an accepted word with either error sets err_sticky and increments err_count. err_count saturates at 2^ERR_W-1.
- clr_err: synchronous; clears err_sticky and err_count.
  - If an errored word is accepted in the same cycle, the error wins: err_sticky=1 and err_count=1.
- Reset values: in_ready=1 (derived), out_valid=0, out_left=0, out_right=0, out_rank=0, out_fmt_err=0, out_seq_err=0, err_sticky=0, err_count=0, expected=(1,0).
- Reset mid-stream: the registered result is dropped. The first word accepted after release is checked against (1,0).
- in_data is ignored when in_valid=0. Behaviour for BW_NUM<3 is undefined.

Test Plan:
- Reset, BW_NUM=4: stream 3,5,6,9,10,12,3 with out_ready=1 -> out_rank 0,1,2,3,4,5,0; (left,right) = (1,0),(2,0),(2,1),(3,0),(3,1),(3,2),(1,0); no errors; err_count=0; one result per cycle with latency 1.
- Skip: stream 3,5,9,10 -> word 9 flags out_seq_err=1 with rank 3; word 10 passes after resync; err_count=1; err_sticky=1.
- Format errors: stream 3,7,0,5 -> words 7 and 0 flag out_fmt_err=1 with left/right/rank=0; word 5 passes because expected was not advanced; err_count=2.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 on word 5 -> in_ready=0 and out_* stays stable; release -> word 5 is accepted exactly once and no word is dropped or duplicated.
- Saturation and clear with ERR_W=2: feed 5 errored words -> err_count sticks at 3; pulse clr_err alone -> 0. Pulse clr_err in the same cycle as an errored accept -> err_count=1, err_sticky=1.
- Async reset: assert rst_b mid-stream while out_valid=1 -> out_valid drops immediately without a clock edge; after release, word 3 passes and word 6 flags out_seq_err=1.
